serial_pattern_tx: RTL and testbench

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/serial_pattern_pkg.sv | 17 +
 rtl/sptx_shifter.sv | 47 ++++
 rtl/serial_pattern_tx.sv | 98 +++++++++
 tb/tb_serial_pattern_tx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_pkg.sv
// Shared state type and encodings for serial_pattern_tx.
// PARITY is always encoded but only used when SPTX_PARITY_EN is defined.
package serial_pattern_pkg;

    localparam logic [1:0] SPTX_ENC_IDLE   = 2'd0;
    localparam logic [1:0] SPTX_ENC_SHIFT  = 2'd1;
    localparam logic [1:0] SPTX_ENC_PARITY = 2'd2;
    localparam logic [1:0] SPTX_ENC_DONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = SPTX_ENC_IDLE,
        ST_SHIFT  = SPTX_ENC_SHIFT,
        ST_PARITY = SPTX_ENC_PARITY,
        ST_DONE   = SPTX_ENC_DONE
    } sptx_state_t;

endpackage

// File: rtl/sptx_shifter.sv
// Payload shift register plus bit counter for serial_pattern_tx.
// Load wins over shift; the counter saturates at WIDTH-1 and never wraps.
module sptx_shifter #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     shift,
    input  logic [WIDTH-1:0]         load_data,
    output logic                     head,
    output logic [$clog2(WIDTH)-1:0] count
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = load_data;
            cnt_d = '0;
        end else if (shift) begin
            if (MSB_FIRST != 0) sr_d = {sr_q[WIDTH-2:0], 1'b0};
            else                sr_d = {1'b0, sr_q[WIDTH-1:1]};
            if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
    assign count = cnt_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// Moore serial transmitter: start in IDLE loads a WIDTH-bit frame shifted one bit per cycle.
// Define SPTX_PARITY_EN to append an even-parity bit after the payload.
module serial_pattern_tx
    import serial_pattern_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             out,
    output logic             busy,
    output logic             done
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sptx_state_t   state_q, state_d;
    logic          load, shift, head;
    logic [CW-1:0] count;

    sptx_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .load_data (data),
        .head      (head),
        .count     (count)
    );

`ifdef SPTX_PARITY_EN
    // Parity is taken from the captured word so later data changes cannot leak in.
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (load) parity_d = ^data;
    end

    always_ff @(posedge clk) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        out     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy  = 1'b1;
                out   = head;
                shift = 1'b1;
                if (count == LAST) begin
`ifdef SPTX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef SPTX_PARITY_EN
            ST_PARITY: begin
                busy    = 1'b1;
                out     = parity_q;
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: directed frames plus random start/reset/data
// against a frame-position reference model, on an MSB-first 8-bit and an LSB-first 5-bit instance.
module tb_serial_pattern_tx;

`ifdef SPTX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int W0 = 8;
    localparam int W1 = 5;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] data;
    logic       out0, busy0, done0;
    logic       out1, busy1, done1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: frame position per instance (-1 = idle), captured word per instance.
    int          pos [2];
    logic [15:0] fd  [2];
    int          wid [2];
    int          msbf[2];

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(W0), .MSB_FIRST(1)) dut0 (
        .clk(clk), .reset(reset), .start(start), .data(data),
        .out(out0), .busy(busy0), .done(done0)
    );

    serial_pattern_tx #(.WIDTH(W1), .MSB_FIRST(0)) dut1 (
        .clk(clk), .reset(reset), .start(start), .data(data[W1-1:0]),
        .out(out1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {out, busy, done} from the position within the frame.
    function automatic logic [2:0] exp_obd(input int i);
        int          w    = wid[i];
        int          flen = wid[i] + PAR;
        logic [15:0] f    = fd[i];
        if (pos[i] < 0)     return 3'b000;
        if (pos[i] < w)     return {(msbf[i] != 0) ? f[w-1-pos[i]] : f[pos[i]], 2'b10};
        if (pos[i] == flen) return 3'b001;
        return {^f, 2'b10};
    endfunction

    function automatic void model_edge(input logic s, input logic r, input logic [7:0] d);
        for (int i = 0; i < 2; i++) begin
            if (r) pos[i] = -1;
            else if (pos[i] < 0) begin
                if (s) begin
                    pos[i] = 0;
                    fd[i]  = 16'(d) & 16'((1 << wid[i]) - 1);
                end
            end else begin
                pos[i]++;
                if (pos[i] > wid[i] + PAR) pos[i] = -1;
            end
        end
    endfunction

    // One clock: drive inputs, advance the model on the edge, check at the falling edge.
    task automatic cyc(input logic s, input logic r, input logic [7:0] d);
        start = s;
        reset = r;
        data  = d;
        @(posedge clk);
        model_edge(s, r, d);
        @(negedge clk);
        chk("i0_out_busy_done", {13'd0, out0, busy0, done0}, {13'd0, exp_obd(0)});
        chk("i1_out_busy_done", {13'd0, out1, busy1, done1}, {13'd0, exp_obd(1)});
    endtask

    initial begin
        logic [7:0] got;
        int         dones;
        wid[0] = W0; msbf[0] = 1;
        wid[1] = W1; msbf[1] = 0;
        pos[0] = -1; pos[1] = -1;
        fd[0]  = '0; fd[1]  = '0;
        start = 1'b0; reset = 1'b1; data = 8'h00;

        repeat (3) cyc(0, 1, 8'h00);
        repeat (2) cyc(0, 0, 8'h00);

        // B4 frame, MSB first: bits 1,0,1,1,0,1,0,0 then one done pulse.
        cyc(1, 0, 8'hB4);
        got = '0;
        for (int k = 0; k < W0; k++) begin
            got[W0-1-k] = out0;
            cyc(0, 0, 8'($urandom));
        end
        chk("b4_bits", {8'd0, got}, 16'h00B4);
`ifndef SPTX_PARITY_EN
        chk("b4_done", {15'd0, done0}, 16'd1);
`endif
        repeat (3) cyc(0, 0, 8'h00);

        // Re-pulse start mid-frame with FF: frame unchanged, no second frame.
        dones = 0;
        cyc(1, 0, 8'hB4);
        got = '0;
        for (int k = 0; k < 14; k++) begin
            if (k < W0) got[W0-1-k] = out0;
            dones += int'(done0);
            cyc((k == 2) ? 1'b1 : 1'b0, 0, 8'hFF);
        end
        chk("repulse_bits", {8'd0, got}, 16'h00B4);
        chk("repulse_dones", 16'(dones), 16'd1);

        // Reset mid-frame: abandon, no done, then a fresh frame.
        cyc(1, 0, 8'hB4);
        repeat (3) cyc(0, 0, 8'h00);
        cyc(0, 1, 8'h00);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            dones += int'(done0);
            cyc(0, 0, 8'h00);
        end
        chk("reset_no_done", 16'(dones), 16'd0);
        cyc(1, 0, 8'h3C);
        repeat (W0 + 3) cyc(0, 0, 8'h00);

        // Reset and start together: stays idle.
        cyc(1, 1, 8'hFF);
        chk("rst_start_busy", {15'd0, busy0}, 16'd0);
        repeat (2) cyc(0, 0, 8'h00);

        // Start held high for 30 cycles with A5.
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(1, 0, 8'hA5);
            dones += int'(done0);
        end
`ifndef SPTX_PARITY_EN
        chk("held_dones", 16'(dones), 16'd3);
`endif
        repeat (W0 + 4) cyc(0, 0, 8'h00);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0,
                8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
